// File: rtl/capture_pkg.sv
// Shared types and constants for the capture run sequencer and its UART byte helper.
package capture_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_CAPTURE, ST_HEADER, ST_READ_REQ, ST_READ_WAIT,
    ST_TX2, ST_TX1, ST_TX0, ST_DONE
  } cap_state_e;

  typedef enum logic [1:0] {SEQ_WAIT, SEQ_PULSE, SEQ_GAP} seq_state_e;

  localparam logic [7:0] HDR_BYTE = 8'hAA;
  localparam int         PAD_W    = 10;
  localparam int         SAMPLE_W = 22;
endpackage

// File: rtl/capture_sequencer_uart_byte_seq.sv
// One UART byte handshake: wait for tx_ready, pulse tx_en for a cycle, then sit out
// one gap cycle because the transmitter drops tx_ready a cycle late.
module uart_byte_seq
  import capture_pkg::*;
(
  input  logic       clk100,
  input  logic       rst_p,
  input  logic       req,
  input  logic [7:0] byte_in,
  input  logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_en,
  output logic       ack
);
  seq_state_e st_q, st_d;
  logic [7:0] byte_q, byte_d;
  logic       en_q, en_d;

  always_comb begin
    st_d   = st_q;
    byte_d = byte_q;
    en_d   = 1'b0;
    case (st_q)
      SEQ_WAIT: if (req && tx_ready) begin
        st_d   = SEQ_PULSE;
        byte_d = byte_in;
        en_d   = 1'b1;
      end
      SEQ_PULSE: st_d = SEQ_GAP;
      default:   st_d = SEQ_WAIT;
    endcase
  end

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p) begin
      st_q   <= SEQ_WAIT;
      byte_q <= '0;
      en_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      byte_q <= byte_d;
      en_q   <= en_d;
    end
  end

  assign tx_byte = byte_q;
  assign tx_en   = en_q;
  // ack coincides with the pulse; the requester moves on while this side is in its gap
  assign ack     = en_q;
endmodule

// File: rtl/capture_sequencer.sv
// Capture a run of sampler words into SDRAM, then replay them over the UART as
// a header byte followed by three bytes per sample.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [22:0] BASE_ADDR = 23'd0
) (
  input  logic                clk100,
  input  logic                rst_p,
  input  logic                arm,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic                sampler_start,
  input  logic                sampler_new_data,
  input  logic [SAMPLE_W-1:0] sampler_data,
  input  logic                mem_cmd_ready,
  output logic                mem_cmd_enable,
  output logic                mem_cmd_wr,
  output logic [22:0]         mem_cmd_address,
  output logic [31:0]         mem_cmd_data,
  input  logic [31:0]         mem_data_out,
  input  logic                mem_data_valid,
  output logic [7:0]          tx_byte,
  output logic                tx_en,
  input  logic                tx_ready
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  cap_state_e          state_q, state_d;
  logic [CW-1:0]       wcount_q, wcount_d, rcount_q, rcount_d;
  logic                full_q, full_d, overrun_q, overrun_d, start_q, start_d;
  logic                cmd_en_q, cmd_en_d, cmd_wr_q, cmd_wr_d;
  logic [22:0]         cmd_addr_q, cmd_addr_d;
  logic [31:0]         cmd_data_q, cmd_data_d;
  logic [SAMPLE_W-1:0] rdata_q, rdata_d;
  logic                accept, seq_req, seq_ack;
  logic [7:0]          seq_byte;
  logic                unused_hi;

  assign accept    = cmd_en_q & mem_cmd_ready;
  assign unused_hi = ^mem_data_out[31:SAMPLE_W];

  always_comb begin
    state_d    = state_q;
    wcount_d   = wcount_q;
    rcount_d   = rcount_q;
    full_d     = full_q;
    overrun_d  = overrun_q;
    start_d    = start_q;
    cmd_en_d   = cmd_en_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    rdata_d    = rdata_q;
    seq_req    = 1'b0;
    seq_byte   = HDR_BYTE;
    case (state_q)
      ST_IDLE: if (arm) begin
        state_d   = ST_CAPTURE;
        overrun_d = 1'b0;
        start_d   = 1'b1;
        wcount_d  = '0;
        full_d    = 1'b0;
      end
      ST_CAPTURE: begin
        if (accept) begin
          full_d   = 1'b0;
          wcount_d = wcount_q + 1'b1;
        end
        // a reload on the accepting edge is legal; only a stalled full register drops
        if (sampler_new_data) begin
          if (full_q && !accept) overrun_d = 1'b1;
          else if (wcount_d != DEPTH_C) begin
            full_d     = 1'b1;
            cmd_data_d = {{PAD_W{1'b0}}, sampler_data};
            cmd_addr_d = BASE_ADDR + 23'(wcount_d);
          end
        end
        if (wcount_d == DEPTH_C) begin
          state_d = ST_HEADER;
          start_d = 1'b0;
          full_d  = 1'b0;
        end
        cmd_en_d = full_d;
        cmd_wr_d = full_d;
      end
      ST_HEADER: begin
        seq_req = 1'b1;
        if (seq_ack) begin
          state_d    = ST_READ_REQ;
          rcount_d   = '0;
          cmd_en_d   = 1'b1;
          cmd_wr_d   = 1'b0;
          cmd_addr_d = BASE_ADDR;
        end
      end
      ST_READ_REQ: if (accept) begin
        cmd_en_d = 1'b0;
        state_d  = ST_READ_WAIT;
      end
      ST_READ_WAIT: if (mem_data_valid) begin
        rdata_d = mem_data_out[SAMPLE_W-1:0];
        state_d = ST_TX2;
      end
      ST_TX2: begin
        seq_req  = 1'b1;
        seq_byte = {2'b00, rdata_q[21:16]};
        if (seq_ack) state_d = ST_TX1;
      end
      ST_TX1: begin
        seq_req  = 1'b1;
        seq_byte = rdata_q[15:8];
        if (seq_ack) state_d = ST_TX0;
      end
      ST_TX0: begin
        seq_req  = 1'b1;
        seq_byte = rdata_q[7:0];
        if (seq_ack) begin
          rcount_d = rcount_q + 1'b1;
          if (rcount_d == DEPTH_C) state_d = ST_DONE;
          else begin
            state_d    = ST_READ_REQ;
            cmd_en_d   = 1'b1;
            cmd_addr_d = BASE_ADDR + 23'(rcount_d);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p) begin
      state_q    <= ST_IDLE;
      wcount_q   <= '0;
      rcount_q   <= '0;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      start_q    <= 1'b0;
      cmd_en_q   <= 1'b0;
      cmd_wr_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wcount_q   <= wcount_d;
      rcount_q   <= rcount_d;
      full_q     <= full_d;
      overrun_q  <= overrun_d;
      start_q    <= start_d;
      cmd_en_q   <= cmd_en_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      rdata_q    <= rdata_d;
    end
  end

  uart_byte_seq u_tx (
    .clk100   (clk100),
    .rst_p    (rst_p),
    .req      (seq_req),
    .byte_in  (seq_byte),
    .tx_ready (tx_ready),
    .tx_byte  (tx_byte),
    .tx_en    (tx_en),
    .ack      (seq_ack)
  );

  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign overrun         = overrun_q;
  assign sampler_start   = start_q;
  assign mem_cmd_enable  = cmd_en_q;
  assign mem_cmd_wr      = cmd_wr_q;
  assign mem_cmd_address = cmd_addr_q;
  assign mem_cmd_data    = cmd_data_q;
endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench: DEPTH=4 at the top of the address space, with SDRAM and UART models.
module tb_capture_sequencer;
  localparam logic [22:0] BASE = 23'h7FFFFC;

  logic        clk100 = 1'b0;
  logic        rst_p, arm, sampler_new_data, mem_cmd_ready, tx_ready;
  logic [21:0] sampler_data;
  logic        busy, done, overrun, sampler_start, mem_cmd_enable, mem_cmd_wr, tx_en;
  logic [22:0] mem_cmd_address;
  logic [31:0] mem_cmd_data, rsp_data, rd_word;
  logic        rsp_vld, stray_vld;
  logic [7:0]  tx_byte;

  logic [31:0] mem_model [4];
  logic [22:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  exp_q [$];
  int          done_cnt, rd_cnt, uart_cnt;
  int          n_vec, n_err;

  always #5 clk100 = ~clk100;

  capture_sequencer #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk100           (clk100),
    .rst_p            (rst_p),
    .arm              (arm),
    .busy             (busy),
    .done             (done),
    .overrun          (overrun),
    .sampler_start    (sampler_start),
    .sampler_new_data (sampler_new_data),
    .sampler_data     (sampler_data),
    .mem_cmd_ready    (mem_cmd_ready),
    .mem_cmd_enable   (mem_cmd_enable),
    .mem_cmd_wr       (mem_cmd_wr),
    .mem_cmd_address  (mem_cmd_address),
    .mem_cmd_data     (mem_cmd_data),
    .mem_data_out     (stray_vld ? 32'h0 : rsp_data),
    .mem_data_valid   (rsp_vld | stray_vld),
    .tx_byte          (tx_byte),
    .tx_en            (tx_en),
    .tx_ready         (tx_ready)
  );

  // SDRAM and UART models: observe at posedge, drive responses at negedge
  always begin
    @(posedge clk100);
    if (!rst_p) begin
      if (mem_cmd_enable && mem_cmd_ready && mem_cmd_wr) begin
        wr_addr_q.push_back(mem_cmd_address);
        wr_data_q.push_back(mem_cmd_data);
        mem_model[mem_cmd_address[1:0]] = mem_cmd_data;
      end
      if (mem_cmd_enable && mem_cmd_ready && !mem_cmd_wr) begin
        rd_cnt  = 7;
        rd_word = mem_model[mem_cmd_address[1:0]];
      end
      if (tx_en) begin
        tx_q.push_back(tx_byte);
        uart_cnt = 6;
      end
      if (done) done_cnt++;
    end
    @(negedge clk100);
    rsp_vld = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        rsp_vld  = 1'b1;
        rsp_data = rd_word;
      end
    end
    tx_ready = (uart_cnt == 0);
    if (uart_cnt > 0) uart_cnt--;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk100);
    arm = 1'b0;
  endtask

  task automatic sample(input logic [21:0] s);
    sampler_new_data = 1'b1;
    sampler_data     = s;
    @(negedge clk100);
    sampler_new_data = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) @(negedge clk100);
    @(negedge clk100);
    chk("done_cnt", 32'(done_cnt), 32'd1);
  endtask

  task automatic check_tx();
    chk("tx_count", 32'(tx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      chk($sformatf("tx_byte[%0d]", i), 32'(tx_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    logic [21:0] run3 [4];
    n_vec = 0; n_err = 0; done_cnt = 0; rd_cnt = 0; uart_cnt = 0;
    rst_p = 1'b1; arm = 1'b0; sampler_new_data = 1'b0; sampler_data = '0;
    mem_cmd_ready = 1'b1; tx_ready = 1'b1; rsp_vld = 1'b0; rsp_data = '0;
    stray_vld = 1'b0; rd_word = '0;
    repeat (3) @(negedge clk100);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_start", 32'(sampler_start), 32'd0);
    chk("rst_en",    32'(mem_cmd_enable), 32'd0);
    chk("rst_txen",  32'(tx_en), 32'd0);
    chk("rst_addr",  32'(mem_cmd_address), 32'd0);
    rst_p = 1'b0;
    @(negedge clk100);

    // Run 1: four spaced samples, ready always high
    pulse_arm();
    chk("arm_start", 32'(sampler_start), 32'd1);
    chk("arm_busy",  32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      sample(22'(i + 1));
      chk("wr_en_next",   32'(mem_cmd_enable), 32'd1);
      chk("wr_addr_next", 32'(mem_cmd_address), 32'(BASE) + 32'(i));
      repeat (19) @(negedge clk100);
    end
    wait_done(600);
    chk("r1_nwr", 32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      chk("r1_waddr", 32'(wr_addr_q[i]), 32'(BASE) + 32'(i));
      chk("r1_wdata", wr_data_q[i], 32'(i + 1));
    end
    exp_q = '{8'hAA, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02,
              8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h04};
    check_tx();
    chk("r1_ovr",  32'(overrun), 32'd0);
    chk("r1_idle", 32'(busy), 32'd0);

    // Run 2: stalled controller, dropped samples, arm while busy, reset mid-capture
    clear_logs();
    mem_cmd_ready = 1'b0;
    pulse_arm();
    sample(22'h0000A1);
    repeat (4) @(negedge clk100);
    sample(22'h0000A2);
    repeat (4) @(negedge clk100);
    sample(22'h0000A3);
    chk("stall_ovr",  32'(overrun), 32'd1);
    chk("stall_en",   32'(mem_cmd_enable), 32'd1);
    chk("stall_addr", 32'(mem_cmd_address), 32'(BASE));
    chk("stall_data", mem_cmd_data, 32'h0000A1);
    repeat (36) @(negedge clk100);
    chk("stall_addr2", 32'(mem_cmd_address), 32'(BASE));
    chk("stall_data2", mem_cmd_data, 32'h0000A1);
    mem_cmd_ready = 1'b1;
    repeat (3) @(negedge clk100);
    chk("stall_nwr", 32'(wr_addr_q.size()), 32'd1);
    if (wr_data_q.size() > 0) chk("stall_wdata", wr_data_q[0], 32'h0000A1);
    pulse_arm();
    chk("barm_ovr",  32'(overrun), 32'd1);
    chk("barm_busy", 32'(busy), 32'd1);
    sample(22'h0000B2);
    chk("barm_addr", 32'(mem_cmd_address), 32'(BASE) + 32'd1);
    rst_p = 1'b1;
    #2;
    chk("mrst_busy",  32'(busy), 32'd0);
    chk("mrst_start", 32'(sampler_start), 32'd0);
    chk("mrst_en",    32'(mem_cmd_enable), 32'd0);
    chk("mrst_ovr",   32'(overrun), 32'd0);
    chk("mrst_addr",  32'(mem_cmd_address), 32'd0);
    @(negedge clk100);
    rst_p = 1'b0;
    @(negedge clk100);

    // Run 3: back-to-back samples land on accepting edges; stray read data during TX1
    clear_logs();
    run3 = '{22'h3FFFFF, 22'h02A5C3, 22'h155A3C, 22'h000080};
    pulse_arm();
    for (int i = 0; i < 4; i++) begin
      sampler_new_data = 1'b1;
      sampler_data     = run3[i];
      @(negedge clk100);
    end
    sampler_new_data = 1'b0;
    @(negedge clk100);
    chk("r3_ovr_cap", 32'(overrun), 32'd0);
    for (int k = 0; k < 300 && tx_q.size() < 2; k++) @(negedge clk100);
    chk("r3_tx_wait", 32'(tx_q.size() >= 2), 32'd1);
    stray_vld = 1'b1;
    @(negedge clk100);
    stray_vld = 1'b0;
    wait_done(800);
    chk("r3_nwr", 32'(wr_addr_q.size()), 32'd4);
    if (wr_addr_q.size() == 4) begin
      chk("r3_waddr0", 32'(wr_addr_q[0]), 32'h7FFFFC);
      chk("r3_waddr3", 32'(wr_addr_q[3]), 32'h7FFFFF);
      chk("r3_wdata0", wr_data_q[0], 32'h003FFFFF);
      chk("r3_wdata2", wr_data_q[2], 32'h00155A3C);
    end
    exp_q = '{8'hAA, 8'h3F, 8'hFF, 8'hFF, 8'h02, 8'hA5, 8'hC3,
              8'h15, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'h80};
    check_tx();
    chk("r3_ovr",  32'(overrun), 32'd0);
    chk("r3_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
